// File: rtl/trace_unloader.sv
`default_nettype none
// ============================================================================
// Module      : trace_unloader
// Description : Pops captured words from the trace buffer read port and
//               serialises each one LSB-first onto tdo, one bit per shift_en
//               strobe. Supports fixed-count unloads, drain-until-empty
//               (num_words = 0) and abort at any time.
// Revision    : 1.0 - initial release
// ============================================================================
module trace_unloader #(
    parameter int Fpay  = 32,
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_words,
    input  logic             abort,
    input  logic [CNT_W-1:0] tb_depth,
    output logic             tb_rd_en,
    input  logic [Fpay-1:0]  tb_dout,
    input  logic             shift_en,
    output logic             tdo,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] word_cnt
);

    localparam int c_bit_w = $clog2(Fpay);
    localparam logic [c_bit_w-1:0] c_last_bit = c_bit_w'(Fpay - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_SHIFT = 2'd3
    } state_t;

    state_t             r_state;
    logic [Fpay-1:0]    r_sreg;
    logic [c_bit_w-1:0] r_bit_cnt;
    logic [CNT_W-1:0]   r_target;
    logic [CNT_W-1:0]   r_word_cnt;
    logic               r_busy;
    logic               r_done;

    logic               w_depth_nz;
    logic               w_last_bit;
    logic               w_cnt_max;
    logic [CNT_W-1:0]   w_cnt_inc;

    assign w_depth_nz = (tb_depth != '0);
    assign w_last_bit = (r_bit_cnt == c_last_bit);
    assign w_cnt_max  = &r_word_cnt;
    assign w_cnt_inc  = r_word_cnt + 1'b1;

    // The pop strobe is only issued from FETCH, which always moves on to WAIT
    // when it pops, so two back-to-back reads can never happen.
    assign tb_rd_en = (r_state == S_FETCH) && w_depth_nz && !abort;

    // The shift register keeps stale bits after an abort, so gate by state.
    assign tdo      = (r_state == S_SHIFT) && r_sreg[0];

    assign busy     = r_busy;
    assign done     = r_done;
    assign word_cnt = r_word_cnt;

    // Unload sequencer: fetch a word, wait for read data, shift it out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_sreg     <= '0;
            r_bit_cnt  <= '0;
            r_target   <= '0;
            r_word_cnt <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state != S_IDLE && abort) begin
                // A partially shifted word is dropped and not counted.
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        // Abort in IDLE suppresses a simultaneous start.
                        if (start && !abort) begin
                            r_target   <= num_words;
                            r_word_cnt <= '0;
                            r_busy     <= 1'b1;
                            r_state    <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        if (w_depth_nz) begin
                            r_state <= S_WAIT;
                        end else if (r_target == '0) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                    S_WAIT: begin
                        r_sreg    <= tb_dout;
                        r_bit_cnt <= '0;
                        r_state   <= S_SHIFT;
                    end
                    S_SHIFT: begin
                        if (shift_en) begin
                            r_sreg    <= {1'b0, r_sreg[Fpay-1:1]};
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            if (w_last_bit) begin
                                if (!w_cnt_max) begin
                                    r_word_cnt <= w_cnt_inc;
                                end
                                if (r_target != '0 && w_cnt_inc == r_target) begin
                                    r_state <= S_IDLE;
                                    r_busy  <= 1'b0;
                                    r_done  <= 1'b1;
                                end else begin
                                    r_state <= S_FETCH;
                                end
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_trace_unloader.sv
`default_nettype none
// ============================================================================
// Module      : tb_trace_unloader
// Description : Scoreboard bench for trace_unloader with a queue-based trace
//               buffer model, a shift_en pattern driver and a tdo monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trace_unloader;

    localparam int FPAY = 32;
    localparam int CW   = 10;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [CW-1:0]   num_words;
    logic            abort;
    logic [CW-1:0]   tb_depth;
    logic            tb_rd_en;
    logic [FPAY-1:0] tb_dout;
    logic            shift_en;
    logic            tdo;
    logic            busy;
    logic            done;
    logic [CW-1:0]   word_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    trace_unloader #(.Fpay(FPAY), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_words (num_words),
        .abort     (abort),
        .tb_depth  (tb_depth),
        .tb_rd_en  (tb_rd_en),
        .tb_dout   (tb_dout),
        .shift_en  (shift_en),
        .tdo       (tdo),
        .busy      (busy),
        .done      (done),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Trace buffer model: destructive FIFO, data valid the cycle after a pop.
    logic [FPAY-1:0] fifo[$];
    logic            wr_req = 1'b0;
    logic [FPAY-1:0] wr_data = '0;
    int              pops = 0;
    initial begin
        tb_dout  = '0;
        tb_depth = '0;
        forever begin
            @(posedge clk);
            if (tb_rd_en) begin
                if (fifo.size() > 0) tb_dout <= fifo.pop_front();
                else fail_now("buffer_underflow");
                pops++;
            end
            if (wr_req) fifo.push_back(wr_data);
            tb_depth <= CW'(fifo.size());
        end
    end

    // shift_en pattern driver: 0 = continuous, 1 = alternate, 2 = random, 3 = off.
    int se_mode = 3;
    bit se_tog  = 1'b0;
    initial begin
        shift_en = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            case (se_mode)
                0: shift_en = 1'b1;
                1: begin se_tog = ~se_tog; shift_en = se_tog; end
                2: shift_en = 1'($urandom_range(0, 1));
                default: shift_en = 1'b0;
            endcase
        end
    end

    // Scoreboard queues filled by the stimulus.
    logic [FPAY-1:0] exp_words[$];
    int              exp_done[$];
    logic [FPAY-1:0] ref_buf[$];

    // Monitor: a pop in cycle c puts bit 0 on tdo in cycle c+2; each strobe
    // seen while shifting consumes one bit; FPAY bits form a word.
    int              arm = 0;
    int              nbits = 0;
    int              mon_words = 0;
    bit              shifting = 1'b0;
    bit              prev_rd = 1'b0;
    logic [FPAY-1:0] cap = '0;
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                arm = 0; nbits = 0; shifting = 1'b0; prev_rd = 1'b0;
            end else begin
                if (done) begin
                    check("done_with_busy_low", busy, 0);
                    if (exp_done.size() == 0) fail_now("done_unexpected");
                    else check("done_word_cnt", word_cnt, exp_done.pop_front());
                end
                if (!busy) begin
                    shifting = 1'b0; arm = 0; nbits = 0;
                end else if (arm > 0) begin
                    arm--;
                    if (arm == 0) shifting = 1'b1;
                end
                if (shifting) begin
                    if (shift_en) begin
                        cap[nbits] = tdo;
                        nbits++;
                        if (nbits == FPAY) begin
                            if (exp_words.size() == 0) fail_now("word_unexpected");
                            else check("word_data", cap, exp_words.pop_front());
                            mon_words++;
                            nbits = 0;
                            shifting = 1'b0;
                        end
                    end
                end else begin
                    check("tdo_zero_outside_shift", tdo, 0);
                end
                if (tb_rd_en) begin
                    check("rd_en_not_consecutive", prev_rd, 0);
                    arm = 2;
                end
                prev_rd = tb_rd_en;
            end
        end
    end

    task automatic write_word(input logic [FPAY-1:0] d);
        @(negedge clk);
        wr_req  = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_req  = 1'b0;
        ref_buf.push_back(d);
    endtask

    task automatic take_expected(input int n);
        for (int i = 0; i < n; i++) exp_words.push_back(ref_buf.pop_front());
        exp_done.push_back(n);
    endtask

    task automatic do_start(input logic [CW-1:0] n);
        @(negedge clk);
        start     = 1'b1;
        num_words = n;
        @(negedge clk);
        start     = 1'b0;
    endtask

    // Counts negedges after the start-sampling edge (first one is 1).
    task automatic wait_done(input int limit, output int cyc, input int restart_at);
        bit seen;
        seen = 1'b0;
        cyc  = 1;
        while (!seen && cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (restart_at > 0 && cyc == restart_at) begin
                start = 1'b1; num_words = CW'(5);
            end
            if (restart_at > 0 && cyc == restart_at + 1) start = 1'b0;
            #3;
            if (done) seen = 1'b1;
        end
        if (!seen) fail_now("done_timeout");
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, p0, d0, base, n, k;
        bit found;
        reset = 1'b1; start = 1'b0; abort = 1'b0; num_words = '0;
        repeat (3) @(negedge clk);
        #3;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_rd_en", tb_rd_en, 0);
        check("reset_tdo", tdo, 0);
        check("reset_word_cnt", word_cnt, 0);
        @(negedge clk);
        reset = 1'b0;

        // Single word, continuous strobes.
        se_mode = 0;
        write_word(32'hA5A5_0F0F);
        take_expected(1);
        p0 = pops;
        do_start(CW'(1));
        wait_done(300, cyc, 0);
        check("single_latency", cyc, 35);
        check("single_rd_count", pops - p0, 1);

        // Drain three words.
        write_word(32'h1); write_word(32'h2); write_word(32'h3);
        take_expected(3);
        do_start(CW'(0));
        wait_done(500, cyc, 0);
        check("drain3_latency", cyc, 104);
        check("drain3_depth_empty", tb_depth, 0);

        // Stall in FETCH while the buffer is empty.
        exp_done.push_back(2);
        do_start(CW'(2));
        repeat (19) @(negedge clk);
        #3;
        check("stall_busy", busy, 1);
        check("stall_rd_en", tb_rd_en, 0);
        write_word($urandom);
        exp_words.push_back(ref_buf.pop_front());
        repeat (80) @(negedge clk);
        #3;
        check("stall2_busy", busy, 1);
        check("stall2_rd_en", tb_rd_en, 0);
        write_word($urandom);
        exp_words.push_back(ref_buf.pop_front());
        wait_done(300, cyc, 0);

        // Alternating strobes: each bit held two cycles.
        se_mode = 1;
        write_word($urandom);
        take_expected(1);
        do_start(CW'(1));
        wait_done(400, cyc, 0);
        check("alt_word_time", (cyc == 66 || cyc == 67), 1);

        // Abort after 10 bits of the second word.
        se_mode = 0;
        write_word($urandom); write_word($urandom); write_word($urandom);
        d0 = ref_buf.size();
        take_expected(1);
        void'(ref_buf.pop_front());
        p0   = pops;
        base = mon_words;
        do_start(CW'(0));
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (mon_words == base + 1 && nbits == 10) found = 1'b1;
        end
        if (!found) fail_now("abort_point_timeout");
        se_mode = 3;
        abort   = 1'b1;
        @(negedge clk);
        abort   = 1'b0;
        #3;
        check("abort_busy", busy, 0);
        check("abort_done", done, 1);
        check("abort_word_cnt", word_cnt, 1);
        check("abort_tdo", tdo, 0);
        check("abort_pops", pops - p0, 2);
        check("abort_depth", tb_depth, d0 - 2);
        se_mode = 0;
        take_expected(ref_buf.size());
        do_start(CW'(0));
        wait_done(300, cyc, 0);
        check("drain1_latency", cyc, 36);

        // Start and abort together in IDLE: abort wins, no done.
        @(negedge clk);
        start = 1'b1; abort = 1'b1; num_words = CW'(3);
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        #3;
        check("start_abort_busy", busy, 0);
        repeat (3) @(negedge clk);
        #3;
        check("start_abort_still_idle", busy, 0);

        // Asynchronous reset mid-shift.
        write_word($urandom);
        void'(ref_buf.pop_front());
        do_start(CW'(1));
        repeat (10) @(negedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("midreset_busy", busy, 0);
        check("midreset_done", done, 0);
        check("midreset_tdo", tdo, 0);
        check("midreset_rd_en", tb_rd_en, 0);
        check("midreset_word_cnt", word_cnt, 0);
        @(negedge clk);
        reset = 1'b0;

        // Restart; a start while busy must not retarget the unload.
        write_word($urandom);
        take_expected(1);
        do_start(CW'(1));
        wait_done(300, cyc, 5);
        check("restart_latency", cyc, 35);

        // Randomised unloads with random strobes.
        se_mode = 2;
        for (int r = 0; r < 6; r++) begin
            n = int'($urandom_range(1, 4));
            for (int i = 0; i < n; i++) write_word($urandom);
            if ($urandom_range(0, 1) == 0) begin
                k = ref_buf.size();
                take_expected(k);
                do_start(CW'(0));
            end else begin
                k = int'($urandom_range(1, ref_buf.size()));
                take_expected(k);
                do_start(CW'(k));
            end
            wait_done(6000, cyc, 0);
            check("rand_depth", tb_depth, ref_buf.size());
        end

        repeat (4) @(negedge clk);
        check("words_all_seen", exp_words.size(), 0);
        check("dones_all_seen", exp_done.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
